// File: rtl/fp_issue_queue.sv
// fp_issue_queue
// Request buffer and tag tracker in front of the APU FPU wrapper. Operations from
// the issue stage are queued in a small FIFO and then dispatched over the APU
// req/gnt handshake. The destination tag of each dispatched operation is kept in
// a tag FIFO, because the wrapper drops tags. Only one FPU operation group may be
// in flight at a time, so results come back in issue order and can be matched to
// tags in FIFO order.
//
// Ports
//   clk_i, rst_ni                      clock, asynchronous active-low reset
//   req_valid_i / req_ready_o          core-side request handshake
//   req_operands_i, req_op_i,
//   req_flags_i, req_tag_i             request payload (operands a,b,c at [0],[1],[2])
//   apu_req_o / apu_gnt_i              FPU-side dispatch handshake
//   apu_operands_o, apu_op_o,
//   apu_flags_o                        FIFO head fields (don't-care when empty)
//   apu_rvalid_i, apu_rdata_i,
//   apu_rflags_i                       FPU result (no back-pressure possible)
//   resp_valid_o, resp_data_o,
//   resp_flags_o, resp_tag_o           registered result with its tag re-attached
//   busy_o                             FIFO non-empty or operations outstanding
//   err_o                              sticky: result arrived with nothing outstanding
//
// Handshakes: a request transfers on any rising edge where req_valid_i && req_ready_o.
// A dispatch transfers on any rising edge where apu_req_o && apu_gnt_i. Once
// apu_req_o is high, it stays high with a stable payload until it is granted.
module fp_issue_queue #(
    parameter int DEPTH           = 2,
    parameter int MAX_OUTSTANDING = 4,
    parameter int TAG_W           = 5
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic [2:0][31:0]      req_operands_i,
    input  logic [5:0]            req_op_i,
    input  logic [10:0]           req_flags_i,
    input  logic [TAG_W-1:0]      req_tag_i,
    output logic                  apu_req_o,
    input  logic                  apu_gnt_i,
    output logic [2:0][31:0]      apu_operands_o,
    output logic [5:0]            apu_op_o,
    output logic [10:0]           apu_flags_o,
    input  logic                  apu_rvalid_i,
    input  logic [31:0]           apu_rdata_i,
    input  logic [4:0]            apu_rflags_i,
    output logic                  resp_valid_o,
    output logic [31:0]           resp_data_o,
    output logic [4:0]            resp_flags_o,
    output logic [TAG_W-1:0]      resp_tag_o,
    output logic                  busy_o,
    output logic                  err_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int TW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int OW = $clog2(MAX_OUTSTANDING) + 1;

    typedef enum logic [1:0] {
        GRP_ADDMUL,
        GRP_DIVSQRT,
        GRP_NONCOMP,
        GRP_CONV
    } grp_e;

    typedef struct packed {
        logic [2:0][31:0] operands;
        logic [5:0]       op;
        logic [10:0]      flags;
        logic [TAG_W-1:0] tag;
    } entry_t;

    function automatic grp_e op_group(input logic [3:0] op);
        grp_e g;
        if (op <= 4'd3)                      g = GRP_ADDMUL;
        else if (op <= 4'd5)                 g = GRP_DIVSQRT;
        else if (op <= 4'd9 || op == 4'd15)  g = GRP_NONCOMP;
        else                                 g = GRP_CONV;
        return g;
    endfunction

    function automatic logic [TW-1:0] tag_ptr_inc(input logic [TW-1:0] p);
        return (p == TW'(MAX_OUTSTANDING - 1)) ? '0 : p + 1'b1;
    endfunction

    // Request FIFO
    entry_t           fifo_mem [DEPTH];
    logic [PW-1:0]    wr_ptr, rd_ptr;
    logic [CW-1:0]    fifo_cnt;
    entry_t           head;
    logic             fifo_empty, fifo_full;

    // Tag FIFO and in-flight tracking
    logic [TAG_W-1:0] tag_mem [MAX_OUTSTANDING];
    logic [TW-1:0]    tag_wr, tag_rd;
    logic [OW-1:0]    outstanding;
    grp_e             inflight_grp;
    grp_e             head_grp;
    logic             out_zero;

    logic             push, issue, dispatch, spurious, ret;
    logic [TAG_W-1:0] ret_tag;

    assign fifo_empty = (fifo_cnt == '0);
    assign fifo_full  = (fifo_cnt == CW'(DEPTH));
    assign head       = fifo_mem[rd_ptr];
    assign head_grp   = op_group(head.op[3:0]);
    assign out_zero   = (outstanding == '0);

    assign push     = req_valid_i && !fifo_full;
    // inflight_grp is meaningless while nothing is outstanding, hence the out_zero bypass.
    assign issue    = !fifo_empty && (outstanding < OW'(MAX_OUTSTANDING))
                      && (out_zero || head_grp == inflight_grp);
    assign dispatch = issue && apu_gnt_i;
    // A same-cycle dispatch makes a zero-latency return legitimate.
    assign spurious = apu_rvalid_i && out_zero && !dispatch;
    assign ret      = apu_rvalid_i && !spurious;
    // With the tag FIFO empty, the only possible owner of the result is the op being granted now.
    assign ret_tag  = out_zero ? head.tag : tag_mem[tag_rd];

    assign req_ready_o    = !fifo_full;
    assign apu_req_o      = issue;
    assign apu_operands_o = head.operands;
    assign apu_op_o       = head.op;
    assign apu_flags_o    = head.flags;
    assign busy_o         = !fifo_empty || !out_zero;

    // Storage arrays carry no reset; their contents are qualified by the counters.
    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_mem[wr_ptr] <= '{operands: req_operands_i, op: req_op_i,
                                  flags: req_flags_i, tag: req_tag_i};
        end
        if (dispatch) begin
            tag_mem[tag_wr] <= head.tag;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            fifo_cnt     <= '0;
            tag_wr       <= '0;
            tag_rd       <= '0;
            outstanding  <= '0;
            inflight_grp <= GRP_ADDMUL;
            resp_valid_o <= 1'b0;
            resp_data_o  <= '0;
            resp_flags_o <= '0;
            resp_tag_o   <= '0;
            err_o        <= 1'b0;
        end else begin
            if (push)     wr_ptr <= wr_ptr + 1'b1;
            if (dispatch) rd_ptr <= rd_ptr + 1'b1;
            case ({push, dispatch})
                2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
                2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
                default: fifo_cnt <= fifo_cnt;
            endcase

            if (dispatch) begin
                tag_wr       <= tag_ptr_inc(tag_wr);
                inflight_grp <= head_grp;
            end
            if (ret) tag_rd <= tag_ptr_inc(tag_rd);
            case ({dispatch, ret})
                2'b10:   outstanding <= outstanding + 1'b1;
                2'b01:   outstanding <= outstanding - 1'b1;
                default: outstanding <= outstanding;
            endcase

            resp_valid_o <= ret;
            if (ret) begin
                resp_data_o  <= apu_rdata_i;
                resp_flags_o <= apu_rflags_i;
                resp_tag_o   <= ret_tag;
            end
            if (spurious) err_o <= 1'b1;
        end
    end

endmodule

// File: doc/fp_issue_queue.md
# fp_issue_queue

Request buffer and tag tracker directly upstream of the APU FPU wrapper. It accepts FP operations from the core's issue stage and queues them. It dispatches them over the APU req/gnt handshake, and records each dispatched operation's destination tag. Because the FPU wrapper drops tags and cannot be back-pressured, this block re-attaches tags to results. It also restricts in-flight operations to one FPU operation group, so results return in issue order.

## Interface
- DEPTH, 2: request FIFO entries; power of two, ≥2.
- MAX_OUTSTANDING, 4: maximum operations granted but not yet returned; power of two, ≥1.
- TAG_W, 5: destination tag width.
- clk_i  in  1  clock; all state on rising edge.
- rst_ni  in  1  asynchronous active-low reset.
- req_valid_i  in  1  core presents an operation.
- req_ready_o  out  1  FIFO can accept; equals !fifo_full (registered state only, no combinational path from gnt).
- req_operands_i  in  3x32  operands a,b,c.
- req_op_i  in  6  {vec, op_mod, op[3:0]}.
- req_flags_i  in  11  {int_fmt[1:0], src_fmt[2:0], dst_fmt[2:0], rnd_mode[2:0]}.
- req_tag_i  in  TAG_W  destination tag.
- apu_req_o  out  1  to FPU wrapper.
- apu_gnt_i  in  1  from FPU wrapper.
- apu_operands_o / apu_op_o / apu_flags_o  out  3x32 / 6 / 11  FIFO head fields.
- apu_rvalid_i  in  1  FPU result valid.
- apu_rdata_i  in  32  FPU result.
- apu_rflags_i  in  5  FPU status {NV,DZ,OF,UF,NX}.
- resp_valid_o  out  1  one-cycle pulse per result.
- resp_data_o  out  32  registered result.
- resp_flags_o  out  5  registered status.
- resp_tag_o  out  TAG_W  tag of the returning operation.
- busy_o  out  1  FIFO non-empty or outstanding≠0.
- err_o  out  1  sticky: result arrived with no outstanding operation.

## Operation
- Request FIFO: push on req_valid_i && req_ready_o. The head drives apu_operands_o, apu_op_o and apu_flags_o continuously. Head fields are don't-care when the FIFO is empty.
- Group of op[3:0]:
  - ADDMUL = 0–3.
  - DIVSQRT = 4–5.
  - NONCOMP = 6–9.
  - CONV = 10–14.
  - Opcode 15 maps to NONCOMP.
- inflight_grp register: holds the group of the operations currently in flight; valid only while outstanding≠0.
- Issue condition: FIFO non-empty, outstanding < MAX_OUTSTANDING, and either outstanding==0 or head group == inflight_grp. apu_req_o = issue condition.
- Holding rule: once apu_req_o is asserted, the head stays stable until gnt. apu_req_o may drop only if outstanding reaches MAX_OUTSTANDING, which cannot happen while it is asserted.
- Dispatch (apu_req_o && apu_gnt_i):
  - Pop the FIFO.
  - Push req_tag into the tag FIFO (depth MAX_OUTSTANDING).
  - outstanding +1.
  - Load inflight_grp with the head group.
- Return (apu_rvalid_i):
  - Pop the tag FIFO.
  - outstanding −1.
  - Register data, flags and the popped tag into resp_*.
  - Pulse resp_valid_o.
- Simultaneous dispatch and return: outstanding unchanged, and the tag FIFO pushes and pops in the same cycle. A result granted and returned in the same cycle (zero-latency FPU) is legal: the returning tag is the incoming one when the tag FIFO is empty (bypass).
- Spurious return: apu_rvalid_i with outstanding==0 and no same-cycle dispatch.
  - Set err_o; it stays set until reset.
  - Drop the result; resp_valid_o stays 0.
  - Counters are unchanged.
- Simultaneous FIFO push and pop when full: not possible, since req_ready_o=0 when full. Push and pop when not full: occupancy unchanged.
- Pointers wrap modulo DEPTH and MAX_OUTSTANDING. Occupancy counters are one bit wider than the pointers.

## Timing
- Reset values: req_ready_o=1; apu_req_o=0; resp_valid_o=0; resp_data_o=0; resp_flags_o=0; resp_tag_o=0; busy_o=0; err_o=0. Both FIFOs are empty and outstanding=0.
- Reset mid-operation: all state clears immediately. Results arriving after deassertion are treated as spurious.
- Enqueue to earliest apu_req_o: 1 cycle, because the FIFO has no fall-through.
- apu_rvalid_i to resp_valid_o: 1 cycle.
- Back-to-back same-group operations issue every cycle while gnt is held high.
- Group switch: the head waits until the cycle after outstanding returns to 0.

## Test plan
- Single ADD (op=2), tag=7, FPU latency 0 → apu_req_o 1 cycle after accept; resp_valid_o 1 cycle after rvalid with resp_tag_o=7 and data passed through; busy_o returns to 0.
- Four MULs (op=3), tags 1–4, FPU latency 2, gnt always 1 → issued on consecutive cycles; responses carry tags 1,2,3,4 in order.
- Fifth same-group operation while four are outstanding → apu_req_o held 0 until the first rvalid, then issues the next cycle.
- ADD tag 3, then DIV (op=4) tag 9 → DIV apu_req_o stays low until the ADD result returns; DIV then issues and returns with tag 9.
- DEPTH=2 FIFO full with gnt=0 → req_ready_o=0 and a third request is not accepted. Raising gnt → one cycle later req_ready_o=1.
- apu_rvalid_i pulse at idle → err_o=1 sticky, no resp_valid_o. Assert rst_ni=0 → err_o=0 asynchronously.
